dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port data memory. It shares the memory between requester A (the CPU load/store stage) and requester B (the debug/DMA loader) using a request/grant handshake with round-robin fairness. It drives the memory's negedge-sampled command inputs and returns read data to the winning requester. It also range-checks every address against the memory depth.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if;
  logic        req_a;
  logic        req_b;
  logic        we_a;
  logic        we_b;
  logic [31:0] addr_a;
  logic [31:0] addr_b;
  logic [31:0] wdata_a;
  logic [31:0] wdata_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        rvalid_a;
  logic        rvalid_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        err_a;
  logic        err_b;
  logic        busy;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] write_address;
  logic [31:0] read_address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, read_data,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, err_a, err_b, busy,
           mem_write, mem_read, write_address, read_address, write_data
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, read_data,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, err_a, err_b, busy,
           mem_write, mem_read, write_address, read_address, write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between
// requester A (CPU) and requester B (debug/DMA), with address range checking.
module dmem_arbiter #(
  parameter int DEPTH = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        prio, prio_next;
  logic        sel_b, sel_b_next;
  logic        op_we, op_we_next;
  logic        op_err, op_err_next;
  logic [31:0] wa_q, wa_next;
  logic [31:0] wd_q, wd_next;
  logic [31:0] ra_q, ra_next;
  logic [31:0] rda_q, rda_next;
  logic [31:0] rdb_q, rdb_next;

  logic        win_b;
  logic        win_we;
  logic        win_err;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

  // prio = 1 hands the tie to B; a lone requester always wins
  assign win_b     = (bus.req_a && bus.req_b) ? prio : bus.req_b;
  assign win_we    = win_b ? bus.we_b    : bus.we_a;
  assign win_addr  = win_b ? bus.addr_b  : bus.addr_a;
  assign win_wdata = win_b ? bus.wdata_b : bus.wdata_a;
  assign win_err   = (win_addr >= DEPTH_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      sel_b  <= 1'b0;
      op_we  <= 1'b0;
      op_err <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      ra_q   <= '0;
      rda_q  <= '0;
      rdb_q  <= '0;
    end else begin
      state  <= state_next;
      prio   <= prio_next;
      sel_b  <= sel_b_next;
      op_we  <= op_we_next;
      op_err <= op_err_next;
      wa_q   <= wa_next;
      wd_q   <= wd_next;
      ra_q   <= ra_next;
      rda_q  <= rda_next;
      rdb_q  <= rdb_next;
    end
  end

  always_comb begin
    state_next  = state;
    prio_next   = prio;
    sel_b_next  = sel_b;
    op_we_next  = op_we;
    op_err_next = op_err;
    wa_next     = wa_q;
    wd_next     = wd_q;
    ra_next     = ra_q;
    rda_next    = rda_q;
    rdb_next    = rdb_q;
    case (state)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          state_next  = ACCESS;
          prio_next   = !win_b;
          sel_b_next  = win_b;
          op_we_next  = win_we;
          op_err_next = win_err;
          // Memory address/data outputs only move for accesses that will strobe
          if (!win_err) begin
            if (win_we) begin
              wa_next = win_addr;
              wd_next = win_wdata;
            end else begin
              ra_next = win_addr;
            end
          end
        end
      end
      ACCESS: begin
        if (op_we) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
          // read_data was refreshed by the memory on the falling edge of this cycle
          if (sel_b) begin
            rdb_next = op_err ? '0 : bus.read_data;
          end else begin
            rda_next = op_err ? '0 : bus.read_data;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output pulses decode registered state only, so req never reaches gnt combinationally
  assign bus.gnt_a         = (state == ACCESS) && !sel_b;
  assign bus.gnt_b         = (state == ACCESS) &&  sel_b;
  assign bus.rvalid_a      = (state == RESP)   && !sel_b;
  assign bus.rvalid_b      = (state == RESP)   &&  sel_b;
  assign bus.err_a         = !sel_b && op_err && (((state == ACCESS) && op_we) || (state == RESP));
  assign bus.err_b         =  sel_b && op_err && (((state == ACCESS) && op_we) || (state == RESP));
  assign bus.busy          = (state != IDLE);
  assign bus.mem_write     = (state == ACCESS) &&  op_we && !op_err;
  assign bus.mem_read      = (state == ACCESS) && !op_we && !op_err;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;
  assign bus.read_address  = ra_q;
  assign bus.rdata_a       = rda_q;
  assign bus.rdata_b       = rdb_q;
endmodule
